mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, default 32, data word width in bits.
REQ-002 Parameter AW, default 32, byte address width in bits.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  access request from core 0 or core 1; held until the matching gnt.
REQ-006 we0, we1  in  1 each  1 = write, 0 = read; qualified by req.
REQ-007 adr0, adr1  in  AW each  byte address; qualified by req.
REQ-008 wd0, wd1  in  DW each  write data; qualified by req and we.
REQ-009 gnt0, gnt1  out  1 each  one-cycle pulse; the access is performed this cycle.
REQ-010 rvalid0, rvalid1  out  1 each  one-cycle pulse; rdata is valid for this read.
REQ-011 rdata  out  DW  registered read data, shared by both cores.
REQ-012 mem_we  out  1  shared-memory write enable.
REQ-013 mem_adr  out  AW  shared-memory address.
REQ-014 mem_wd  out  DW  shared-memory write data.
REQ-015 mem_rd  in  DW  shared-memory read data; combinational from mem_adr.

Function
REQ-016 FSM states are IDLE, ACCESS and RESP.
REQ-017 In IDLE with any req high, the arbiter shall select one core, latch its we, adr and wd, and move to ACCESS.
REQ-018 In IDLE with both req low, the FSM shall stay in IDLE and the latches shall hold.
REQ-019 With exactly one req high, that core shall win.
REQ-020 With both req high, the core named by the 1-bit priority pointer ptr shall win.
REQ-021 ptr shall become the index of the loser after every IDLE->ACCESS transition, giving round-robin order.
REQ-022 In ACCESS, mem_adr shall equal the latched adr, mem_wd the latched wd, and mem_we the latched we.
REQ-023 In ACCESS, gnt of the selected core shall be 1.
REQ-024 A write in ACCESS shall commit at the ending edge, and the FSM shall then go ACCESS->IDLE.
REQ-025 A read in ACCESS shall load mem_rd into rdata at the ending edge, and the FSM shall then go ACCESS->RESP.
REQ-026 In RESP, rvalid of the selected core shall be 1 and rdata shall hold; the FSM shall then go RESP->IDLE.
REQ-027 Latency from req sampled high in IDLE: gnt after 1 cycle; read rvalid after 2 cycles.
REQ-028 Idle-to-idle occupancy shall be 2 cycles for a write and 3 cycles for a read.
REQ-029 req is sampled only in IDLE; req changes in ACCESS or RESP shall not affect the latched transaction.
REQ-030 A req still high in the first IDLE cycle after its gnt shall be treated as a new request.
REQ-031 Outside ACCESS, mem_we shall be 0 and mem_adr shall equal the latched adr.
REQ-032 At most one of gnt0/gnt1, and at most one of rvalid0/rvalid1, shall be high in any cycle.
REQ-033 rdata shall change only on the ACCESS->RESP edge.

Reset
REQ-034 Asserting reset shall force IDLE, ptr=0, all latched fields 0, rdata=0, and all gnt, rvalid and mem_we outputs 0, with no clock edge required.
REQ-035 A reset during ACCESS or RESP shall abort the transaction: no pending gnt or rvalid, and mem_we shall drop immediately.
REQ-036 On the first clock edge after reset deassertion, the FSM shall arbitrate normally.

Structure
REQ-037 The state enum arb_state_t and the encodings IDLE/ACCESS/RESP shall live in shared package mp_pkg.
REQ-038 The round-robin selection shall be a combinational sub-module rr_pick, with inputs req0, req1, ptr and outputs valid, sel.
REQ-039 All state, ptr, latches and rdata shall be in a single always_ff block with asynchronous active-low reset.

Verification
REQ-040 Single write: req0=1, we0=1, adr0=0x10, wd0=0xDEADBEEF at IDLE -> next cycle gnt0=1, mem_we=1, mem_adr=0x10, mem_wd=0xDEADBEEF; IDLE follows.
REQ-041 Single read: memory word 0x10=0xDEADBEEF, req1=1, we1=0, adr1=0x10 -> gnt1 at +1 cycle, rvalid1=1 and rdata=0xDEADBEEF at +2 cycles.
REQ-042 Contention: req0=req1=1 held after reset -> grants alternate gnt0, gnt1, gnt0, gnt1; neither core is starved.
REQ-043 Late drop: req0 deasserted during ACCESS -> the latched read still completes, and rvalid0 pulses once.
REQ-044 Reset mid-read: reset asserted in ACCESS -> gnt, mem_we and rvalid go 0 at once; no rvalid after release; ptr=0.
REQ-045 Back-to-back: core 0 holds req through its gnt, with core 1 idle -> a second core-0 access is granted in the next IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the dual-core shared-memory arbiter.
// FSM state encoding and the round-robin pointer update rule.
package mp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // The losing core is favoured at the next contended decision.
    function automatic logic next_ptr(input logic sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response bundle plus the shared-memory port.
// slave = arbiter view; master = cores and memory (environment) view.
interface mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] adr0;
    logic [AW-1:0] adr1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_adr, mem_wd
    );

    modport master (
        output req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_adr, mem_wd
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, otherwise ptr decides.
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic valid,
    output logic sel
);

    always_comb begin
        valid = req0 | req1;
        sel   = (req0 & req1) ? ptr : req1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two cores onto one shared memory port: IDLE picks and latches a
// request, ACCESS drives the memory for one cycle, RESP returns read data.
module mem_arbiter
    import mp_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t    r_state;
    logic          r_ptr;
    logic          r_sel;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wd;
    logic [DW-1:0] r_rdata;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_mem_we;

    logic          w_valid;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_wd;

    rr_pick u_rr_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .ptr   (r_ptr),
        .valid (w_valid),
        .sel   (w_sel)
    );

    always_comb begin
        w_we  = bus.we0;
        w_adr = bus.adr0;
        w_wd  = bus.wd0;
        if (w_sel) begin
            w_we  = bus.we1;
            w_adr = bus.adr1;
            w_wd  = bus.wd1;
        end
    end

    // Strobes default low each cycle; only the transition edges raise them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_wd      <= '0;
            r_rdata   <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_sel    <= w_sel;
                        r_ptr    <= next_ptr(w_sel);
                        r_we     <= w_we;
                        r_adr    <= w_adr;
                        r_wd     <= w_wd;
                        r_gnt0   <= ~w_sel;
                        r_gnt1   <= w_sel;
                        r_mem_we <= w_we;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_rdata   <= bus.mem_rd;
                        r_rvalid0 <= ~r_sel;
                        r_rvalid1 <= r_sel;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = r_rdata;
    assign bus.mem_we  = r_mem_we;
    assign bus.mem_adr = r_adr;
    assign bus.mem_wd  = r_wd;

endmodule
